fetch_ctrl: RTL and testbench

Sequencing controller for the fetch stage (program counter + instruction memory). Generates the PC pause and PC write-enable, arbitrates redirect requests from exception, branch and jump sources, and holds fetch during the post-reset boot window. Drives a flush pulse to the IF/ID register after each accepted redirect, and optionally parks fetch on a halt request.

---
 rtl/fetch_ctrl.sv | 151 +++++++++++++++
 tb/tb_fetch_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencing controller: boot hold, redirect arbitration, IF/ID flush and optional halt parking.
// Optional halt support is compiled in when FETCH_CTRL_HALT_EN is defined.
module fetch_ctrl #(
    parameter int          BOOT_CYCLES  = 4,
    parameter int          FLUSH_CYCLES = 1,
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_0004
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_FetchCtrl_stall,
    input  logic        i_FetchCtrl_exc,
    input  logic        i_FetchCtrl_br_valid,
    input  logic [31:0] i_FetchCtrl_br_target,
    input  logic        i_FetchCtrl_j_valid,
    input  logic [31:0] i_FetchCtrl_j_target,
    input  logic        i_FetchCtrl_halt,
    output logic        o_FetchCtrl_pause,
    output logic        o_FetchCtrl_we,
    output logic [31:0] o_FetchCtrl_PC,
    output logic        o_FetchCtrl_flush,
    output logic [2:0]  o_FetchCtrl_state
);

    localparam logic [2:0] ST_BOOT  = 3'd0;
    localparam logic [2:0] ST_RUN   = 3'd1;
    localparam logic [2:0] ST_STALL = 3'd2;
    localparam logic [2:0] ST_FLUSH = 3'd3;
    localparam logic [2:0] ST_HALT  = 3'd4;

    logic [2:0]  state_r;
    logic [2:0]  state_nxt_s;
    logic [7:0]  boot_cnt_r;
    logic [7:0]  boot_cnt_nxt_s;
    logic [2:0]  flush_cnt_r;
    logic [2:0]  flush_cnt_nxt_s;
    logic        accept_s;
    logic [31:0] pc_s;
    logic        halt_req_s;

`ifdef FETCH_CTRL_HALT_EN
    assign halt_req_s = i_FetchCtrl_halt;
`else
    logic halt_unused_s;
    assign halt_unused_s = i_FetchCtrl_halt;
    assign halt_req_s    = 1'b0;
`endif

    // Redirect arbitration: exception beats branch beats jump; only exceptions leave HALT.
    always_comb begin
        accept_s = 1'b0;
        pc_s     = 32'h0000_0000;
        case (state_r)
            ST_RUN, ST_STALL, ST_FLUSH: begin
                if (i_FetchCtrl_exc) begin
                    accept_s = 1'b1;
                    pc_s     = EXC_VECTOR;
                end else if (i_FetchCtrl_br_valid) begin
                    accept_s = 1'b1;
                    pc_s     = i_FetchCtrl_br_target;
                end else if (i_FetchCtrl_j_valid) begin
                    accept_s = 1'b1;
                    pc_s     = i_FetchCtrl_j_target;
                end else begin
                    accept_s = 1'b0;
                    pc_s     = 32'h0000_0000;
                end
            end
            ST_HALT: begin
                if (i_FetchCtrl_exc) begin
                    accept_s = 1'b1;
                    pc_s     = EXC_VECTOR;
                end else begin
                    accept_s = 1'b0;
                    pc_s     = 32'h0000_0000;
                end
            end
            default: begin
                accept_s = 1'b0;
                pc_s     = 32'h0000_0000;
            end
        endcase
    end

    // Next-state and counter update; an accepted redirect always wins over stall and halt.
    always_comb begin
        state_nxt_s     = state_r;
        boot_cnt_nxt_s  = boot_cnt_r;
        flush_cnt_nxt_s = flush_cnt_r;
        if (accept_s) begin
            state_nxt_s     = ST_FLUSH;
            flush_cnt_nxt_s = 3'(FLUSH_CYCLES);
        end else begin
            case (state_r)
                ST_BOOT: begin
                    if (boot_cnt_r <= 8'd1) begin
                        state_nxt_s = ST_RUN;
                    end else begin
                        boot_cnt_nxt_s = boot_cnt_r - 8'd1;
                    end
                end
                ST_RUN, ST_STALL: begin
                    if (halt_req_s) begin
                        state_nxt_s = ST_HALT;
                    end else if (i_FetchCtrl_stall) begin
                        state_nxt_s = ST_STALL;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end
                ST_FLUSH: begin
                    if (flush_cnt_r <= 3'd1) begin
                        state_nxt_s     = i_FetchCtrl_stall ? ST_STALL : ST_RUN;
                        flush_cnt_nxt_s = 3'd0;
                    end else begin
                        flush_cnt_nxt_s = flush_cnt_r - 3'd1;
                    end
                end
                ST_HALT: begin
                    state_nxt_s = ST_HALT;
                end
                default: begin
                    state_nxt_s     = ST_BOOT;
                    boot_cnt_nxt_s  = 8'(BOOT_CYCLES);
                    flush_cnt_nxt_s = 3'd0;
                end
            endcase
        end
    end

    // State and counter registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_BOOT;
            boot_cnt_r  <= 8'(BOOT_CYCLES);
            flush_cnt_r <= 3'd0;
        end else begin
            state_r     <= state_nxt_s;
            boot_cnt_r  <= boot_cnt_nxt_s;
            flush_cnt_r <= flush_cnt_nxt_s;
        end
    end

    assign o_FetchCtrl_we    = accept_s;
    assign o_FetchCtrl_PC    = pc_s;
    assign o_FetchCtrl_pause = (state_r == ST_BOOT)
                             | ((state_r == ST_HALT) & ~accept_s)
                             | (i_FetchCtrl_stall & ~accept_s);
    assign o_FetchCtrl_flush = (state_r == ST_FLUSH);
    assign o_FetchCtrl_state = state_r;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed self-checking bench for fetch_ctrl (BOOT_CYCLES=4, FLUSH_CYCLES=3).
// Halt scenarios follow FETCH_CTRL_HALT_EN when it is defined for the build.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        exc = 1'b0;
    logic        br_valid = 1'b0;
    logic [31:0] br_target = 32'h0;
    logic        j_valid = 1'b0;
    logic [31:0] j_target = 32'h0;
    logic        halt = 1'b0;
    logic        pause;
    logic        we;
    logic [31:0] pc;
    logic        flush;
    logic [2:0]  state;
    int          total = 0;
    int          bad = 0;

    // observed vector layout: {pause, we, flush, state[2:0], pc[31:0]}
    wire [37:0] obs = {pause, we, flush, state, pc};

    fetch_ctrl #(.BOOT_CYCLES(4), .FLUSH_CYCLES(3), .EXC_VECTOR(32'h0000_0004)) dut (
        .clk(clk), .rst(rst),
        .i_FetchCtrl_stall(stall), .i_FetchCtrl_exc(exc),
        .i_FetchCtrl_br_valid(br_valid), .i_FetchCtrl_br_target(br_target),
        .i_FetchCtrl_j_valid(j_valid), .i_FetchCtrl_j_target(j_target),
        .i_FetchCtrl_halt(halt),
        .o_FetchCtrl_pause(pause), .o_FetchCtrl_we(we), .o_FetchCtrl_PC(pc),
        .o_FetchCtrl_flush(flush), .o_FetchCtrl_state(state)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        total++;
        if (obs !== {1'b1, 1'b0, 1'b0, 3'd0, 32'h0}) begin
            bad++; $display("FAIL reset_values got=%h want=%h", obs, {1'b1, 1'b0, 1'b0, 3'd0, 32'h0});
        end
        step();
        step();
    endtask

    task automatic test_boot();
        rst = 1'b0;
        br_valid = 1'b1;
        br_target = 32'h0000_1234;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++;
            if (obs !== {1'b1, 1'b0, 1'b0, 3'd0, 32'h0}) begin
                bad++; $display("FAIL boot_cycle%0d got=%h want=%h", i, obs, {1'b1, 1'b0, 1'b0, 3'd0, 32'h0});
            end
            step();
        end
        #1;
        total++;
        if (obs !== {1'b0, 1'b1, 1'b0, 3'd1, 32'h0000_1234}) begin
            bad++; $display("FAIL boot_first_we got=%h want=%h", obs, {1'b0, 1'b1, 1'b0, 3'd1, 32'h0000_1234});
        end
        step();
        br_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if (obs !== {1'b0, 1'b0, 1'b1, 3'd3, 32'h0}) begin
                bad++; $display("FAIL boot_flush%0d got=%h want=%h", i, obs, {1'b0, 1'b0, 1'b1, 3'd3, 32'h0});
            end
            step();
        end
        #1;
        total++;
        if (obs !== {1'b0, 1'b0, 1'b0, 3'd1, 32'h0}) begin
            bad++; $display("FAIL boot_run_idle got=%h want=%h", obs, {1'b0, 1'b0, 1'b0, 3'd1, 32'h0});
        end
        step();
    endtask

    task automatic test_priority();
        exc = 1'b1; br_valid = 1'b1; j_valid = 1'b1;
        br_target = 32'h0000_0100; j_target = 32'h0000_0200;
        #1;
        total++;
        if (obs !== {1'b0, 1'b1, 1'b0, 3'd1, 32'h0000_0004}) begin
            bad++; $display("FAIL prio_exc got=%h want=%h", obs, {1'b0, 1'b1, 1'b0, 3'd1, 32'h0000_0004});
        end
        step();
        exc = 1'b0; j_valid = 1'b0;
        #1;
        total++;
        if (obs !== {1'b0, 1'b1, 1'b1, 3'd3, 32'h0000_0100}) begin
            bad++; $display("FAIL prio_br_over_j got=%h want=%h", obs, {1'b0, 1'b1, 1'b1, 3'd3, 32'h0000_0100});
        end
        step();
        br_valid = 1'b0; j_valid = 1'b1;
        #1;
        total++;
        if (obs !== {1'b0, 1'b1, 1'b1, 3'd3, 32'h0000_0200}) begin
            bad++; $display("FAIL prio_j got=%h want=%h", obs, {1'b0, 1'b1, 1'b1, 3'd3, 32'h0000_0200});
        end
        step();
        j_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if (obs !== {1'b0, 1'b0, 1'b1, 3'd3, 32'h0}) begin
                bad++; $display("FAIL prio_flush%0d got=%h want=%h", i, obs, {1'b0, 1'b0, 1'b1, 3'd3, 32'h0});
            end
            step();
        end
        #1;
        total++;
        if (obs !== {1'b0, 1'b0, 1'b0, 3'd1, 32'h0}) begin
            bad++; $display("FAIL prio_back_to_run got=%h want=%h", obs, {1'b0, 1'b0, 1'b0, 3'd1, 32'h0});
        end
    endtask

    task automatic test_stall();
        stall = 1'b1; j_valid = 1'b1; j_target = 32'h0000_0040;
        #1;
        total++;
        if (obs !== {1'b0, 1'b1, 1'b0, 3'd1, 32'h0000_0040}) begin
            bad++; $display("FAIL stall_redirect got=%h want=%h", obs, {1'b0, 1'b1, 1'b0, 3'd1, 32'h0000_0040});
        end
        step();
        j_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if (obs !== {1'b1, 1'b0, 1'b1, 3'd3, 32'h0}) begin
                bad++; $display("FAIL stall_flush%0d got=%h want=%h", i, obs, {1'b1, 1'b0, 1'b1, 3'd3, 32'h0});
            end
            step();
        end
        #1;
        total++;
        if (obs !== {1'b1, 1'b0, 1'b0, 3'd2, 32'h0}) begin
            bad++; $display("FAIL stall_state got=%h want=%h", obs, {1'b1, 1'b0, 1'b0, 3'd2, 32'h0});
        end
        stall = 1'b0;
        #1;
        total++;
        if (obs !== {1'b0, 1'b0, 1'b0, 3'd2, 32'h0}) begin
            bad++; $display("FAIL stall_release got=%h want=%h", obs, {1'b0, 1'b0, 1'b0, 3'd2, 32'h0});
        end
        step();
        #1;
        total++;
        if (obs !== {1'b0, 1'b0, 1'b0, 3'd1, 32'h0}) begin
            bad++; $display("FAIL stall_to_run got=%h want=%h", obs, {1'b0, 1'b0, 1'b0, 3'd1, 32'h0});
        end
    endtask

    task automatic test_back_to_back();
        int n_flush;
        br_valid = 1'b1; br_target = 32'h0000_0060;
        step();
        br_valid = 1'b0;
        step();
        br_valid = 1'b1; br_target = 32'h0000_0080;
        #1;
        total++;
        if (obs !== {1'b0, 1'b1, 1'b1, 3'd3, 32'h0000_0080}) begin
            bad++; $display("FAIL b2b_reload_we got=%h want=%h", obs, {1'b0, 1'b1, 1'b1, 3'd3, 32'h0000_0080});
        end
        step();
        br_valid = 1'b0;
        n_flush = 2;
        for (int i = 0; i < 6; i++) begin
            if (flush === 1'b1) n_flush++;
            step();
        end
        total++;
        if (n_flush !== 5) begin
            bad++; $display("FAIL b2b_flush_len got=%0d want=%0d", n_flush, 5);
        end
        #1;
        total++;
        if (obs !== {1'b0, 1'b0, 1'b0, 3'd1, 32'h0}) begin
            bad++; $display("FAIL b2b_end got=%h want=%h", obs, {1'b0, 1'b0, 1'b0, 3'd1, 32'h0});
        end
    endtask

    task automatic test_halt();
        halt = 1'b1; br_valid = 1'b1; br_target = 32'h0000_0500;
        step();
        br_valid = 1'b0;
        #1;
        total++;
        if (obs !== {1'b0, 1'b0, 1'b1, 3'd3, 32'h0}) begin
            bad++; $display("FAIL halt_redirect_wins got=%h want=%h", obs, {1'b0, 1'b0, 1'b1, 3'd3, 32'h0});
        end
        step(); step(); step();
`ifdef FETCH_CTRL_HALT_EN
        step();
        halt = 1'b0; br_valid = 1'b1;
        #1;
        total++;
        if (obs !== {1'b1, 1'b0, 1'b0, 3'd4, 32'h0}) begin
            bad++; $display("FAIL halt_br_ignored got=%h want=%h", obs, {1'b1, 1'b0, 1'b0, 3'd4, 32'h0});
        end
        step();
        br_valid = 1'b0; exc = 1'b1;
        #1;
        total++;
        if (obs !== {1'b0, 1'b1, 1'b0, 3'd4, 32'h0000_0004}) begin
            bad++; $display("FAIL halt_exc got=%h want=%h", obs, {1'b0, 1'b1, 1'b0, 3'd4, 32'h0000_0004});
        end
        step();
        exc = 1'b0;
        #1;
        total++;
        if (obs !== {1'b0, 1'b0, 1'b1, 3'd3, 32'h0}) begin
            bad++; $display("FAIL halt_exit_flush got=%h want=%h", obs, {1'b0, 1'b0, 1'b1, 3'd3, 32'h0});
        end
        step(); step(); step();
`else
        step();
        #1;
        total++;
        if (obs !== {1'b0, 1'b0, 1'b0, 3'd1, 32'h0}) begin
            bad++; $display("FAIL halt_ignored got=%h want=%h", obs, {1'b0, 1'b0, 1'b0, 3'd1, 32'h0});
        end
        halt = 1'b0;
`endif
    endtask

    task automatic test_reset_mid_flush();
        br_valid = 1'b1; br_target = 32'h0000_0700;
        step();
        br_valid = 1'b0;
        rst = 1'b1;
        #1;
        total++;
        if (obs !== {1'b1, 1'b0, 1'b0, 3'd0, 32'h0}) begin
            bad++; $display("FAIL rst_mid_flush got=%h want=%h", obs, {1'b1, 1'b0, 1'b0, 3'd0, 32'h0});
        end
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) step();
        #1;
        total++;
        if (obs !== {1'b0, 1'b0, 1'b0, 3'd1, 32'h0}) begin
            bad++; $display("FAIL rst_reboot_run got=%h want=%h", obs, {1'b0, 1'b0, 1'b0, 3'd1, 32'h0});
        end
    endtask

    initial begin
        test_reset();
        test_boot();
        test_priority();
        step();
        test_stall();
        step();
        test_back_to_back();
        step();
        test_halt();
        test_reset_mid_flush();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
